// File: rtl/y86_fetch_prefetch_if.sv
// Bundle between the prefetching fetch stage, instruction memory and the decode consumer.
// "master" is the fetch stage; "slave" is the memory/consumer side.
interface y86_fetch_prefetch_if #(
    parameter int FETCH_BYTES = 8
);
    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [63:0]                imem_req_addr;
    logic                       imem_rsp_valid;
    logic [8*FETCH_BYTES-1:0]   imem_rsp_data;
    logic                       imem_rsp_error;

    logic                       out_valid;
    logic                       out_ready;
    logic [3:0]                 icode;
    logic [3:0]                 ifun;
    logic [3:0]                 rA;
    logic [3:0]                 rB;
    logic [63:0]                valC;
    logic [63:0]                valP;
    logic [63:0]                pc_out;
    logic [63:0]                pred_pc;
    logic                       instruct_error;
    logic                       imem_error;
    logic                       halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_error,
        output out_valid, icode, ifun, rA, rB, valC, valP, pc_out, pred_pc,
        output instruct_error, imem_error, halted,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_error,
        input  out_valid, icode, ifun, rA, rB, valC, valP, pc_out, pred_pc,
        input  instruct_error, imem_error, halted,
        output out_ready
    );
endinterface

// File: rtl/y86_fetch_prefetch.sv
// Y86-64 fetch stage with a circular prefetch byte buffer, decode from the buffer head,
// redirect, next-PC prediction and halt/error stop.
module y86_fetch_prefetch #(
    parameter int          FETCH_BYTES = 8,
    parameter int          BUF_BYTES   = 32,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [63:0]                 redirect_pc,
    y86_fetch_prefetch_if.master        bus
);
    localparam int PTR_W  = $clog2(BUF_BYTES);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SKIP_W = $clog2(FETCH_BYTES);
    localparam logic [63:0]      ALIGN_MASK = ~(64'(FETCH_BYTES) - 64'd1);
    localparam logic [CNT_W-1:0] BUF_CNT    = CNT_W'(BUF_BYTES);
    localparam logic [CNT_W-1:0] FETCH_CNT  = CNT_W'(FETCH_BYTES);

    logic [7:0]        r_buf [BUF_BYTES];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic [63:0]       r_pc;
    logic [63:0]       r_fetchAddr;
    logic [SKIP_W-1:0] r_skip;
    logic              r_outstanding;
    logic              r_stale;
    logic              r_errPending;
    logic              r_stopped;
    logic              r_halted;

    logic [7:0]        w_head [10];
    logic [3:0]        w_icode;
    logic [3:0]        w_ifun;
    logic              w_invalid;
    logic              w_hasReg;
    logic              w_hasValC;
    logic              w_valCAt1;
    logic [3:0]        w_len;
    logic [63:0]       w_valC;
    logic [63:0]       w_valP;
    logic              w_errCase;
    logic              w_outValid;
    logic              w_fire;
    logic              w_reqFire;
    logic              w_rspTake;
    logic              w_rspWrite;
    logic [CNT_W-1:0]  w_push;
    logic [CNT_W-1:0]  w_pop;

    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_head[k] = r_buf[r_rdPtr + PTR_W'(k)];
        end
    end

    assign w_icode = w_head[0][7:4];
    assign w_ifun  = w_head[0][3:0];

    always_comb begin
        w_len     = 4'd1;
        w_hasReg  = 1'b0;
        w_hasValC = 1'b0;
        w_valCAt1 = 1'b0;
        w_invalid = 1'b0;
        case (w_icode)
            4'h0, 4'h1, 4'h9: w_invalid = (w_ifun != 4'd0);
            4'h2: begin
                w_len = 4'd2; w_hasReg = 1'b1; w_invalid = (w_ifun > 4'd6);
            end
            4'h3, 4'h4, 4'h5: begin
                w_len = 4'd10; w_hasReg = 1'b1; w_hasValC = 1'b1; w_invalid = (w_ifun != 4'd0);
            end
            4'h6: begin
                w_len = 4'd2; w_hasReg = 1'b1; w_invalid = (w_ifun > 4'd3);
            end
            4'h7: begin
                w_len = 4'd9; w_hasValC = 1'b1; w_valCAt1 = 1'b1; w_invalid = (w_ifun > 4'd6);
            end
            4'h8: begin
                w_len = 4'd9; w_hasValC = 1'b1; w_valCAt1 = 1'b1; w_invalid = (w_ifun != 4'd0);
            end
            4'hA, 4'hB: begin
                w_len = 4'd2; w_hasReg = 1'b1; w_invalid = (w_ifun != 4'd0);
            end
            default: w_invalid = 1'b1;
        endcase
        if (w_invalid) begin
            w_len     = 4'd1;
            w_hasReg  = 1'b0;
            w_hasValC = 1'b0;
            w_valCAt1 = 1'b0;
        end
    end

    always_comb begin
        w_valC = '0;
        for (int j = 0; j < 8; j++) begin
            if (w_hasValC) begin
                w_valC[8*j +: 8] = w_valCAt1 ? w_head[j+1] : w_head[j+2];
            end
        end
    end

    // A faulty fetch leaves the tail of the instruction unreadable, so it has no real length.
    assign w_errCase  = r_errPending && (r_count < CNT_W'(w_len));
    assign w_outValid = !r_stopped && ((r_count >= CNT_W'(w_len)) || r_errPending);
    assign w_valP     = w_errCase ? r_pc : r_pc + 64'(w_len);
    assign w_fire     = w_outValid && bus.out_ready;
    assign w_reqFire  = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rspTake  = bus.imem_rsp_valid && r_outstanding;
    assign w_rspWrite = w_rspTake && !r_stale && !bus.imem_rsp_error;
    assign w_push     = w_rspWrite ? (FETCH_CNT - CNT_W'(r_skip)) : '0;
    assign w_pop      = (w_fire && !w_errCase) ? CNT_W'(w_len) : '0;

    // Fetching stops after a fault: later words would land after a hole in the byte stream.
    assign bus.imem_req_valid = !rst && !r_stopped && !r_outstanding && !r_errPending &&
                                ((BUF_CNT - r_count) >= FETCH_CNT);
    assign bus.imem_req_addr  = r_fetchAddr;
    assign bus.halted         = r_halted;

    always_comb begin
        bus.out_valid      = w_outValid;
        bus.icode          = 4'h0;
        bus.ifun           = 4'h0;
        bus.rA             = 4'hF;
        bus.rB             = 4'hF;
        bus.valC           = '0;
        bus.valP           = '0;
        bus.pc_out         = '0;
        bus.pred_pc        = '0;
        bus.instruct_error = 1'b0;
        bus.imem_error     = 1'b0;
        if (w_outValid) begin
            bus.pc_out  = r_pc;
            bus.valP    = w_valP;
            bus.pred_pc = w_valP;
            if (w_errCase) begin
                bus.imem_error = 1'b1;
            end else begin
                bus.icode          = w_icode;
                bus.ifun           = w_ifun;
                bus.valC           = w_valC;
                bus.instruct_error = w_invalid;
                if (w_hasReg) begin
                    bus.rA = w_head[1][7:4];
                    bus.rB = w_head[1][3:0];
                end
                if (w_valCAt1) begin
                    bus.pred_pc = w_valC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_count       <= '0;
            r_pc          <= RESET_PC;
            r_fetchAddr   <= RESET_PC & ALIGN_MASK;
            r_skip        <= RESET_PC[SKIP_W-1:0];
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
            r_errPending  <= 1'b0;
            r_stopped     <= 1'b0;
            r_halted      <= 1'b0;
        end else if (redirect_valid) begin
            // A request still in flight (or issued this very cycle) belongs to the old stream.
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_count       <= '0;
            r_pc          <= redirect_pc;
            r_fetchAddr   <= redirect_pc & ALIGN_MASK;
            r_skip        <= redirect_pc[SKIP_W-1:0];
            r_outstanding <= (r_outstanding && !bus.imem_rsp_valid) || w_reqFire;
            r_stale       <= (r_outstanding && !bus.imem_rsp_valid) || w_reqFire;
            r_errPending  <= 1'b0;
            r_stopped     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_count <= r_count + w_push - w_pop;
            r_rdPtr <= r_rdPtr + w_pop[PTR_W-1:0];
            r_wrPtr <= r_wrPtr + w_push[PTR_W-1:0];
            if (w_fire) begin
                if (w_errCase) begin
                    r_stopped <= 1'b1;
                end else begin
                    r_pc <= w_valP;
                    if (w_invalid) begin
                        r_stopped <= 1'b1;
                    end else if (w_icode == 4'h0) begin
                        r_halted  <= 1'b1;
                        r_stopped <= 1'b1;
                    end
                end
            end
            if (w_reqFire) begin
                r_outstanding <= 1'b1;
                r_fetchAddr   <= r_fetchAddr + 64'(FETCH_BYTES);
            end
            if (w_rspTake) begin
                r_outstanding <= 1'b0;
                r_stale       <= 1'b0;
                if (!r_stale) begin
                    r_skip <= '0;
                    if (bus.imem_rsp_error) begin
                        r_errPending <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && w_rspWrite) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                if (k >= int'(r_skip)) begin
                    r_buf[r_wrPtr + PTR_W'(k) - PTR_W'(r_skip)] <= bus.imem_rsp_data[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_y86_fetch_prefetch.sv
// Self-checking bench for y86_fetch_prefetch: a 1-cycle-latency memory model feeds the DUT
// and hand-written expected instructions are queued and compared as they are delivered.
module tb_y86_fetch_prefetch;
    localparam int FB = 8;
    localparam int BB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    y86_fetch_prefetch_if #(.FETCH_BYTES(FB)) bus ();

    y86_fetch_prefetch #(
        .FETCH_BYTES(FB),
        .BUF_BYTES(BB),
        .RESET_PC(64'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [63:0] predPc;
        logic        instErr;
        logic        memErr;
        logic        chkFull;
    } expT;

    expT         expQ[$];
    logic [63:0] reqLog[$];
    logic [7:0]  mem [256];
    logic        errWord [32];
    int          nChecks = 0;
    int          nPass = 0;
    logic        monEnable = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic pushExp(input logic [63:0] pc, input logic [3:0] icode, input logic [3:0] ifun,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valC,
                           input logic [63:0] valP, input logic [63:0] predPc,
                           input logic instErr, input logic memErr, input logic chkFull);
        expT e;
        e.pc = pc; e.icode = icode; e.ifun = ifun; e.ra = ra; e.rb = rb;
        e.valC = valC; e.valP = valP; e.predPc = predPc;
        e.instErr = instErr; e.memErr = memErr; e.chkFull = chkFull;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int addr, input logic [7:0] val);
        mem[addr] = val;
    endtask

    task automatic fillMem(input logic [7:0] val);
        for (int i = 0; i < 256; i++) mem[i] = val;
        for (int i = 0; i < 32; i++) errWord[i] = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reqLog.delete();
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
    endtask

    // Memory model: a request seen before a rising edge is answered for the following edge.
    initial begin
        logic        memPending;
        logic [63:0] memAddr;
        logic [7:0]  idx;
        memPending = 1'b0;
        memAddr = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_error = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_error = 1'b0;
            if (memPending) begin
                for (int k = 0; k < FB; k++) begin
                    idx = memAddr[7:0] + 8'(k);
                    bus.imem_rsp_data[8*k +: 8] = mem[idx];
                end
                bus.imem_rsp_error = errWord[memAddr[7:3]];
                bus.imem_rsp_valid = 1'b1;
                memPending = 1'b0;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                memPending = 1'b1;
                memAddr = bus.imem_req_addr;
                reqLog.push_back(bus.imem_req_addr);
            end
        end
    end

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            #1;
            if (monEnable && bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraOut", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pc_out", bus.pc_out, e.pc);
                    checkOutput("icode", 64'(bus.icode), 64'(e.icode));
                    checkOutput("ifun", 64'(bus.ifun), 64'(e.ifun));
                    checkOutput("valC", bus.valC, e.valC);
                    checkOutput("instErr", 64'(bus.instruct_error), 64'(e.instErr));
                    checkOutput("memErr", 64'(bus.imem_error), 64'(e.memErr));
                    if (e.chkFull) begin
                        checkOutput("rA", 64'(bus.rA), 64'(e.ra));
                        checkOutput("rB", 64'(bus.rB), 64'(e.rb));
                        checkOutput("valP", bus.valP, e.valP);
                        checkOutput("predPc", bus.pred_pc, e.predPc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int snap;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.out_ready = 1'b0;
        fillMem(8'h00);
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rstOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("rstReqValid", 64'(bus.imem_req_valid), 64'd0);
        checkOutput("rstRa", 64'(bus.rA), 64'hF);
        checkOutput("rstRb", 64'(bus.rB), 64'hF);
        checkOutput("rstValP", bus.valP, 64'd0);
        checkOutput("rstPredPc", bus.pred_pc, 64'd0);
        checkOutput("rstPcOut", bus.pc_out, 64'd0);
        checkOutput("rstHalted", 64'(bus.halted), 64'd0);
        checkOutput("rstIcode", 64'(bus.icode), 64'd0);
        checkOutput("rstValC", bus.valC, 64'd0);
        monEnable = 1'b1;

        // irmovq $9,%rdx followed by halt
        applyStimulus(0, 8'h30); applyStimulus(1, 8'hF2); applyStimulus(2, 8'h09);
        pushExp(64'd0, 4'h3, 4'h0, 4'hF, 4'h2, 64'd9, 64'd10, 64'd10, 1'b0, 1'b0, 1'b1);
        pushExp(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd11, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain(100);
        repeat (4) @(negedge clk);
        #2;
        checkOutput("haltHalted", 64'(bus.halted), 64'd1);
        checkOutput("haltOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("haltReqValid", 64'(bus.imem_req_valid), 64'd0);

        pushExp(64'd0, 4'h3, 4'h0, 4'hF, 4'h2, 64'd9, 64'd10, 64'd10, 1'b0, 1'b0, 1'b1);
        pushExp(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd11, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        checkOutput("redirHaltClr", 64'(bus.halted), 64'd0);
        waitDrain(100);

        // OPq, jXX, nop, halt
        resetDut();
        fillMem(8'h00);
        applyStimulus(0, 8'h60); applyStimulus(1, 8'h23);
        applyStimulus(2, 8'h70); applyStimulus(3, 8'h40);
        applyStimulus(11, 8'h10);
        pushExp(64'd0, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 64'd2, 1'b0, 1'b0, 1'b1);
        pushExp(64'd2, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd11, 64'h40, 1'b0, 1'b0, 1'b1);
        pushExp(64'd11, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd12, 64'd12, 1'b0, 1'b0, 1'b1);
        pushExp(64'd12, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd13, 64'd13, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain(100);

        // back-pressure on a nop stream
        resetDut();
        fillMem(8'h10);
        for (int i = 0; i < 40; i++) begin
            pushExp(64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), 64'(i + 1), 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        checkOutput("bpReqCount10", 64'(reqLog.size()), 64'd4);
        checkOutput("bpPcOut10", bus.pc_out, 64'd0);
        checkOutput("bpOutValid10", 64'(bus.out_valid), 64'd1);
        repeat (10) @(negedge clk);
        #2;
        checkOutput("bpReqCount20", 64'(reqLog.size()), 64'd4);
        checkOutput("bpReqValid", 64'(bus.imem_req_valid), 64'd0);
        checkOutput("bpPcOut20", bus.pc_out, 64'd0);
        checkOutput("bpIcode20", 64'(bus.icode), 64'd1);
        checkOutput("bpValP20", bus.valP, 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        waitDrain(300);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // redirect to 0x13 in the same cycle the first request is accepted
        resetDut();
        fillMem(8'h10);
        applyStimulus(8'h13, 8'h60); applyStimulus(8'h14, 8'h45); applyStimulus(8'h15, 8'h00);
        pushExp(64'h13, 4'h6, 4'h0, 4'h4, 4'h5, 64'd0, 64'h15, 64'h15, 1'b0, 1'b0, 1'b1);
        pushExp(64'h15, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h16, 64'h16, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h13;
        bus.out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        waitDrain(100);
        checkOutput("staleReqAddr", (reqLog.size() > 0) ? reqLog[0] : 64'hDEAD, 64'h0);
        checkOutput("redirReqAddr", (reqLog.size() > 1) ? reqLog[1] : 64'hDEAD, 64'h10);

        // invalid byte C0 at pc 5
        resetDut();
        fillMem(8'h10);
        applyStimulus(5, 8'hC0);
        for (int i = 0; i < 5; i++) begin
            pushExp(64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), 64'(i + 1), 1'b0, 1'b0, 1'b1);
        end
        pushExp(64'd5, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd6, 64'd6, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain(100);
        repeat (3) @(negedge clk);
        #2;
        snap = reqLog.size();
        repeat (8) @(negedge clk);
        #2;
        checkOutput("ieNoReq", 64'(reqLog.size()), 64'(snap));
        checkOutput("ieOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("ieHalted", 64'(bus.halted), 64'd0);

        // memory fault on the word at 0x8 under an irmovq starting at 0x4
        resetDut();
        fillMem(8'h10);
        applyStimulus(4, 8'h30); applyStimulus(5, 8'hF3);
        for (int i = 6; i < 14; i++) applyStimulus(i, 8'(8'h11 + 8'(i - 6)));
        errWord[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushExp(64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), 64'(i + 1), 1'b0, 1'b0, 1'b1);
        end
        pushExp(64'd4, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain(100);
        repeat (6) @(negedge clk);
        #2;
        checkOutput("meOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("meReqValid", 64'(bus.imem_req_valid), 64'd0);
        checkOutput("meImemErr", 64'(bus.imem_error), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
